// File: rtl/folded_neuron_if.sv
// rtl/folded_neuron_if.sv - operand/result handshake bundle for folded_neuron
interface folded_neuron_if #(
    parameter int N         = 64,
    parameter int precision = 16
);
    logic                        in_valid;
    logic                        in_ready;
    logic signed [precision-1:0] bias;
    logic signed [precision-1:0] weights [N-1:0];
    logic signed [precision-1:0] x [N-1:0];
    logic                        act_mode;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [precision-1:0] output_result;
    logic                        sat_flag;

    // upstream/downstream side: supplies operands, consumes results
    modport master (
        output in_valid, bias, weights, x, act_mode, out_ready,
        input  in_ready, out_valid, output_result, sat_flag
    );

    // neuron side
    modport slave (
        input  in_valid, bias, weights, x, act_mode, out_ready,
        output in_ready, out_valid, output_result, sat_flag
    );
endinterface

// File: rtl/folded_neuron.sv
// rtl/folded_neuron.sv - time-multiplexed fixed-point neuron with M MAC lanes
module folded_neuron #(
    parameter int N         = 64,
    parameter int M         = 8,
    parameter int precision = 16,
    parameter int FRAC      = 8
) (
    input  logic           clk,
    input  logic           rst,
    folded_neuron_if.slave bus
);
    localparam int G  = N / M;
    localparam int CW = (G > 1) ? $clog2(G) : 1;
    localparam int PW = 2 * precision;
    localparam int AW = 2 * precision + $clog2(N) + 1;

    localparam logic signed [AW-1:0] OUT_MAX = {{(AW-precision+1){1'b0}}, {(precision-1){1'b1}}};
    localparam logic signed [AW-1:0] OUT_MIN = {{(AW-precision+1){1'b1}}, {(precision-1){1'b0}}};

    if ((M < 1) || (M > N) || ((N % M) != 0)) begin : g_bad_cfg
        $error("folded_neuron: N must be a positive multiple of M with 1 <= M <= N");
    end

    if ((FRAC < 0) || (FRAC >= precision)) begin : g_bad_frac
        $error("folded_neuron: FRAC must satisfy 0 <= FRAC < precision");
    end

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t                      state;
    logic [CW-1:0]               cnt;
    logic signed [AW-1:0]        acc;
    logic signed [precision-1:0] x_r [N-1:0];
    logic signed [precision-1:0] w_r [N-1:0];
    logic                        act_r;
    logic                        out_valid_r;
    logic                        sat_r;
    logic signed [precision-1:0] result_r;

    logic signed [AW-1:0]        group_sum;
    logic signed [AW-1:0]        acc_next;
    logic signed [AW-1:0]        r_shift;
    logic signed [AW-1:0]        r_act;
    logic signed [precision-1:0] r_out;
    logic                        r_clip;

    assign bus.in_ready      = (state == IDLE) & ~rst;
    assign bus.out_valid     = out_valid_r;
    assign bus.output_result = result_r;
    assign bus.sat_flag      = sat_r;

    // Operands shift down by M each BUSY cycle, so the current group always sits in lanes 0..M-1
    always_comb begin
        group_sum = '0;
        for (int j = 0; j < M; j++) begin
            group_sum = group_sum + AW'(PW'(x_r[j]) * PW'(w_r[j]));
        end
    end

    // Result formation for the final group: shift, optional ReLU, then clamp to the output range
    always_comb begin
        acc_next = acc + group_sum;
        r_shift  = acc_next >>> FRAC;
        r_act    = (act_r && r_shift[AW-1]) ? '0 : r_shift;
        r_clip   = 1'b0;
        r_out    = r_act[precision-1:0];
        if (r_act > OUT_MAX) begin
            r_out  = OUT_MAX[precision-1:0];
            r_clip = 1'b1;
        end else if (r_act < OUT_MIN) begin
            r_out  = OUT_MIN[precision-1:0];
            r_clip = 1'b1;
        end
    end

    // Control FSM with accumulator, operand store and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= '0;
            act_r       <= 1'b0;
            out_valid_r <= 1'b0;
            sat_r       <= 1'b0;
            result_r    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        for (int i = 0; i < N; i++) begin
                            x_r[i] <= bus.x[i];
                            w_r[i] <= bus.weights[i];
                        end
                        act_r <= bus.act_mode;
                        acc   <= AW'(bus.bias) <<< FRAC;
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    for (int i = 0; i < N - M; i++) begin
                        x_r[i] <= x_r[i+M];
                        w_r[i] <= w_r[i+M];
                    end
                    if (cnt == CW'(G - 1)) begin
                        result_r    <= r_out;
                        sat_r       <= r_clip;
                        out_valid_r <= 1'b1;
                        cnt         <= '0;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/folded_neuron.md
Name: folded_neuron

Overview:
- Time-multiplexed successor to the fully parallel neuron: one neuron of N inputs computed with M MAC lanes over N/M cycles.
- Signed fixed-point with FRAC fractional bits, wide accumulation, runtime-selectable activation (identity or ReLU) and saturating output.
- Valid/ready handshakes on input and output, so it chains between the layer controller and the next layer's input buffer.

Parameters:
- N, 64, inputs per neuron; N must be a multiple of M (elaboration-time assertion).
- M, 8, MAC lanes evaluated per cycle; 1 <= M <= N.
- precision, 16, bit width of x, weights, bias and output_result (two's complement).
- FRAC, 8, fractional bits of every operand and of the result; 0 <= FRAC < precision.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  bias/weights/x/act_mode are valid.
- in_ready  output  1  block can accept an operand set.
- bias  input  precision  signed bias, FRAC fractional bits.
- weights  input  N x precision  signed weights, unpacked [N-1:0].
- x  input  N x precision  signed activations, unpacked [N-1:0].
- act_mode  input  1  0 = identity, 1 = ReLU; sampled on input handshake.
- out_valid  output  1  output_result/sat_flag are valid.
- out_ready  input  1  downstream accepts the result.
- output_result  output  precision  activated, saturated neuron output.
- sat_flag  output  1  result was clipped during saturation.

Behaviour:
- Reset: state IDLE, out_valid=0, output_result=0, sat_flag=0, cnt=0, acc=0. in_ready=0 while rst=1.
- in_ready = (state==IDLE) & ~rst. Input handshake = in_valid & in_ready.
- On input handshake: register all N x, N weights and act_mode. acc <= sign-extended bias << FRAC. cnt <= 0. Go to BUSY.
- Inputs are don't-care outside the handshake cycle.
- BUSY, each cycle: acc <= acc + sum over lanes j=0..M-1 of x_r[cnt*M+j]*w_r[cnt*M+j].
  - Products are full 2*precision signed.
  - acc width is 2*precision + clog2(N) + 1, so it never overflows.
  - cnt increments each BUSY cycle.
- When cnt==N/M-1, the final group is added and the result is formed in the same edge:
  - Step 1: r = acc_final >>> FRAC (arithmetic shift, truncation toward -inf).
  - Step 2: if act_mode=1 and r<0, r = 0.
  - Step 3: clamp r to [-2^(precision-1), 2^(precision-1)-1]. sat_flag = 1 if clamped.
  - Register output_result and sat_flag, set out_valid=1, go to DONE.
- Latency: out_valid rises exactly N/M clock edges after the input handshake edge (default 8).
- DONE:
  - output_result, sat_flag and out_valid hold stable until out_valid & out_ready.
  - On that edge: out_valid <= 0, go to IDLE. output_result keeps its last value.
  - in_ready stays 0 in DONE, so there is no same-cycle re-accept. Throughput is one neuron per N/M+2 cycles.
- M==N: BUSY lasts one cycle (cnt==0 is the final group).
- rst=1 in any state, including mid-BUSY or DONE with out_ready=0: the next edge forces reset values. The partial result is discarded and no out_valid pulse is produced.
- out_ready while not in DONE is ignored. in_valid while not in IDLE is ignored; the operands are not captured.
- States: IDLE -(in handshake)-> BUSY -(cnt==N/M-1)-> DONE -(out handshake)-> IDLE.

Test Plan:
- Basic MAC (N=4, M=2, precision=16, FRAC=8): all x=256 (1.0), all w=256, bias=0, act_mode=0 -> out_valid exactly 2 edges after accept, output_result=1024, sat_flag=0.
- ReLU vs identity: x={256,256,256,256}, w={-512,-512,-512,-512}, bias=128.
  - act_mode=0 -> output_result=-1920.
  - Repeat with act_mode=1 -> output_result=0, sat_flag=0.
- Saturation: all x=w=32512 (127.0), bias=0.
  - act_mode=0 -> output_result=32767, sat_flag=1.
  - w=-32512 -> output_result=-32768, sat_flag=1.
  - Same with act_mode=1 -> output_result=0, sat_flag=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> output_result/out_valid stable and in_ready=0 throughout. in_valid pulsed with new data during DONE is not captured. After out_ready=1, in_ready=1 next cycle.
- Reset mid-operation: assert rst one cycle after the handshake (BUSY) -> next edge out_valid=0, output_result=0, in_ready=1 after rst drops. A fresh operand set then gives the correct result with the nominal latency.
- Default config (N=64, M=8): random signed operands, 1000 back-to-back transactions with random out_ready -> every result matches the golden model (wide sum, >>>FRAC, ReLU, clamp). Latency is always 8 cycles.
